// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, state encoding and control-word layout for the sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OPC_BITS  = 5;
    localparam int unsigned RSEL_BITS = 4;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_BITS-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_BITS-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_BITS-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_BITS-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_BITS-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPC_BITS-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPC_BITS-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPC_BITS-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_BITS-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_BITS-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_BITS-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_BINARY  = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_UNARY   = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // Datapath strobes and status decoded for one sequencer step.
    typedef struct packed {
        logic                 pc_out;
        logic                 mar_in;
        logic                 inc_pc;
        logic                 z_in;
        logic                 zlo_out;
        logic                 zhi_out;
        logic                 pc_in;
        logic                 read;
        logic                 mdr_in;
        logic                 mdr_out;
        logic                 ir_in;
        logic                 y_in;
        logic                 lo_in;
        logic                 hi_in;
        logic                 rout_en;
        logic [RSEL_BITS-1:0] rout_sel;
        logic                 rin_en;
        logic [RSEL_BITS-1:0] rin_sel;
        logic [OPC_BITS-1:0]  operation;
        logic                 busy;
        logic                 halted;
        logic                 illegal;
    } ctrl_word_t;

    // Group an opcode by the execute path it takes after decode.
    function automatic op_class_t classify(input logic [OPC_BITS-1:0] opc);
        op_class_t cls;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BINARY;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_NOP:                         cls = CLS_NOP;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Moore decode of the current step and instruction fields into the control word.
module ctrl_step_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t                state,
    input  logic                  first_t1,
    input  logic [OPC_BITS-1:0]   opcode,
    input  logic [RSEL_BITS-1:0]  ra,
    input  logic [RSEL_BITS-1:0]  rb,
    input  logic [RSEL_BITS-1:0]  rc,
    output ctrl_word_t            word
);

    op_class_t cls;

    assign cls = classify(opcode);

    // Strobe pattern per step; everything defaults low so IDLE and reset decode to zero.
    always_comb begin
        word = '0;
        case (state)
            S_T0: begin
                word.pc_out    = 1'b1;
                word.mar_in    = 1'b1;
                word.inc_pc    = 1'b1;
                word.z_in      = 1'b1;
                word.operation = OP_ADD;
                word.busy      = 1'b1;
            end
            S_T1: begin
                word.zlo_out = 1'b1;
                word.pc_in   = first_t1;
                word.read    = 1'b1;
                word.mdr_in  = 1'b1;
                word.busy    = 1'b1;
            end
            S_T2: begin
                word.mdr_out = 1'b1;
                word.ir_in   = 1'b1;
                word.busy    = 1'b1;
            end
            S_T3: begin
                word.operation = opcode;
                word.busy      = 1'b1;
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        word.rout_en  = 1'b1;
                        word.rout_sel = rb;
                        word.y_in     = 1'b1;
                    end
                    CLS_UNARY: begin
                        word.rout_en  = 1'b1;
                        word.rout_sel = rb;
                        word.z_in     = 1'b1;
                    end
                    CLS_ILLEGAL: word.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                word.operation = opcode;
                word.busy      = 1'b1;
                word.rout_en   = 1'b1;
                word.rout_sel  = rc;
                word.z_in      = 1'b1;
            end
            S_T5: begin
                word.operation = opcode;
                word.busy      = 1'b1;
                word.zlo_out   = 1'b1;
                if (cls == CLS_MULDIV) begin
                    word.lo_in = 1'b1;
                end else begin
                    word.rin_en  = 1'b1;
                    word.rin_sel = ra;
                end
            end
            S_T6: begin
                word.operation = opcode;
                word.busy      = 1'b1;
                word.zhi_out   = 1'b1;
                word.hi_in     = 1'b1;
            end
            S_HALT: word.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction fetch/execute control sequencer: step register plus strobe decode.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned RSEL_W = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic              mem_ready,
    output logic              PCout,
    output logic              MARin,
    output logic              IncPC,
    output logic              Zin,
    output logic              ZLOout,
    output logic              ZHIout,
    output logic              PCin,
    output logic              read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              LOin,
    output logic              HIin,
    output logic              rout_en,
    output logic [RSEL_W-1:0] rout_sel,
    output logic              rin_en,
    output logic [RSEL_W-1:0] rin_sel,
    output logic [OPC_W-1:0]  operation,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    state_t              state;
    logic                first_t1;
    logic [OPC_BITS-1:0] opcode;
    op_class_t           cls;
    ctrl_word_t          word;
    logic                unused_ir_bits;

    assign opcode         = ir[31:27];
    assign cls            = classify(opcode);
    assign unused_ir_bits = ^ir[14:0];

    // Step register; first_t1 marks the T1 cycle entered straight from T0 so PCin fires once per fetch.
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            first_t1 <= 1'b0;
        end else begin
            first_t1 <= (state == S_T0);
            case (state)
                S_IDLE: if (start) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (mem_ready) state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3: begin
                    case (cls)
                        CLS_BINARY, CLS_MULDIV: state <= S_T4;
                        CLS_UNARY:              state <= S_T5;
                        CLS_HALT:               state <= S_HALT;
                        default:                state <= S_T0;
                    endcase
                end
                S_T4:   state <= S_T5;
                S_T5:   state <= (cls == CLS_MULDIV) ? S_T6 : S_T0;
                S_T6:   state <= S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    ctrl_step_decode u_decode (
        .state    (state),
        .first_t1 (first_t1),
        .opcode   (opcode),
        .ra       (ir[26:23]),
        .rb       (ir[22:19]),
        .rc       (ir[18:15]),
        .word     (word)
    );

    // Fan the decoded control word out to the named datapath strobes.
    always_comb begin
        PCout     = word.pc_out;
        MARin     = word.mar_in;
        IncPC     = word.inc_pc;
        Zin       = word.z_in;
        ZLOout    = word.zlo_out;
        ZHIout    = word.zhi_out;
        PCin      = word.pc_in;
        read      = word.read;
        MDRin     = word.mdr_in;
        MDRout    = word.mdr_out;
        IRin      = word.ir_in;
        Yin       = word.y_in;
        LOin      = word.lo_in;
        HIin      = word.hi_in;
        rout_en   = word.rout_en;
        rout_sel  = RSEL_W'(word.rout_sel);
        rin_en    = word.rin_en;
        rin_sel   = RSEL_W'(word.rin_sel);
        operation = OPC_W'(word.operation);
        busy      = word.busy;
        halted    = word.halted;
        illegal   = word.illegal;
    end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter: OPC_W, default 5, opcode field width taken from ir[31:27].
REQ-002 Parameter: RSEL_W, default 4, register-select width for ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, with ports named clock and clear.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 clear  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle pulse that leaves IDLE.
REQ-007 ir  in  32  current IR register contents.
REQ-008 mem_ready  in  1  memory data valid this cycle.
REQ-009 PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath strobes.
REQ-010 rout_en / rout_sel  out  1 / 4  general-register bus-drive enable and index.
REQ-011 rin_en / rin_sel  out  1 / 4  general-register load enable and index.
REQ-012 operation  out  5  ALU opcode; equals ir[31:27] in execute states, ADD (00011) in T0, otherwise 0.
REQ-013 busy / halted / illegal  out  1 each  status flags.

Function
REQ-014 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT; all outputs SHALL be Moore-decoded from the state and ir only.
REQ-015 IDLE: all strobes low; start=1 -> T0; otherwise stay in IDLE.
REQ-016 T0: PCout, MARin, IncPC, Zin asserted -> T1.
REQ-017 T1: ZLOout, PCin, read, MDRin asserted; PCin only in the first T1 cycle; stay in T1 while mem_ready=0; mem_ready=1 -> T2.
REQ-018 T2: MDRout, IRin asserted -> T3.
REQ-019 T3 decode on ir[31:27] for binary ops (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV): rout_sel=rb, rout_en, Yin asserted -> T4.
REQ-020 T3 decode for unary ops (NEG, NOT): rout_sel=rb, rout_en, Zin asserted -> T5.
REQ-021 T3 decode: NOP -> T0; HALT -> HALT; any other opcode sets illegal for one cycle -> T0.
REQ-022 T4: rout_sel=rc, rout_en, Zin asserted -> T5.
REQ-023 T5 for MUL/DIV: ZLOout, LOin asserted -> T6; for other ops: ZLOout, rin_en, rin_sel=ra asserted -> T0.
REQ-024 T6: ZHIout, HIin asserted -> T0.
REQ-025 HALT: halted=1 and all strobes low; remain until clear.
REQ-026 busy SHALL be 1 in T0..T6 and 0 in IDLE and HALT.
REQ-027 Latency from T0 with mem_ready tied high: binary 6 cycles, MUL/DIV 7, unary 5, NOP 4.
REQ-028 At most one bus-driving strobe (PCout, ZLOout, ZHIout, MDRout, rout_en) SHALL be high in any cycle.
REQ-029 start SHALL be ignored outside IDLE.

Reset
REQ-030 clear=1 at a clock edge SHALL force IDLE with all outputs 0, from any state including mid-T1 waits and HALT.

Structure
REQ-031 Opcode constants (ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHL=01000, ROR=01001, ROL=01010, MUL=01111, DIV=10000, NEG=10001, NOT=10010, NOP=11010, HALT=11011) and the state encoding SHALL live in shared package cpu_ctrl_pkg.
REQ-032 One sub-module, ctrl_step_decode (combinational state+opcode -> strobes), is natural; the state register stays in ctrl_sequencer.

Verification
REQ-033 ADD: start, ir=0x18918000, mem_ready=1 -> T0..T5 in 6 cycles; T3 rout_sel=2 with Yin; T4 rout_sel=3 with Zin and operation=00011; T5 rin_sel=1.
REQ-034 MUL: ir=0x78228000 -> T5 asserts ZLOout+LOin, T6 asserts ZHIout+HIin; 7 cycles; rin_en never high.
REQ-035 Memory stall: mem_ready low for 3 cycles in T1 -> T1 held 4 cycles, read high throughout, PCin high only in the first.
REQ-036 HALT: ir=0xD8000000 -> HALT after T3; halted=1; start pulses ignored; clear -> IDLE, halted=0.
REQ-037 Illegal opcode: ir[31:27]=11111 -> illegal pulses 1 cycle in T3, next state T0, no rin_en.
REQ-038 clear asserted during T4 -> next cycle IDLE, all strobes 0, busy=0.
